// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle shared by the byte-stream requesters, the transmit
// arbiter and the uart transmitter's data input.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic                 en_i;
   logic [NUM_REQ-1:0]   req_valid_i;
   logic [NUM_REQ*8-1:0] req_data_i;
   logic [NUM_REQ-1:0]   req_last_i;
   logic [NUM_REQ-1:0]   req_ready_o;
   logic                 tx_data_valid_o;
   logic [7:0]           tx_data_o;
   logic                 tx_data_ready_i;
   logic [NUM_REQ-1:0]   grant_o;
   logic                 busy_o;

   // Requesters and uart: drive requests and tx ready, observe grants
   modport master (
      output en_i, req_valid_i, req_data_i, req_last_i, tx_data_ready_i,
      input  req_ready_o, tx_data_valid_o, tx_data_o, grant_o, busy_o
   );

   // Arbiter: consumes requests and tx ready, produces the shared channel
   modport slave (
      input  en_i, req_valid_i, req_data_i, req_last_i, tx_data_ready_i,
      output req_ready_o, tx_data_valid_o, tx_data_o, grant_o, busy_o
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter that shares one uart transmit channel between
// NUM_REQ byte-stream requesters. A grant is held until the granted
// requester's last byte is accepted, so packets never interleave. An optional
// header byte (HDR_BASE + requester index) precedes each packet.
module uart_tx_arbiter #(
   parameter int         NUM_REQ  = 4,
   parameter bit         HDR_EN   = 1'b1,
   parameter logic [7:0] HDR_BASE = 8'hA0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   uart_tx_arbiter_if.slave io
);
   localparam int IDX_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HEADER = 2'd1,
      DATA   = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_vld;
   logic [7:0]         req_byte [NUM_REQ];
   logic [NUM_REQ-1:0] ready;
   logic [NUM_REQ-1:0] grant;
   logic               tx_valid;
   logic [7:0]         tx_data;

   // (base + off) modulo NUM_REQ; off never exceeds NUM_REQ-1
   function automatic logic [IDX_W-1:0] wrap_idx(input int base, input int off);
      int s;
      s = base + off;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return IDX_W'(s);
   endfunction

   // Split the flat data bus into one byte per requester
   always_comb begin
      for (int k = 0; k < NUM_REQ; k++) begin
         req_byte[k] = io.req_data_i[k*8 +: 8];
      end
   end

   // First valid requester at or above the pointer, wrapping; walking the
   // offsets downward lets the smallest offset win without an early exit
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (io.req_valid_i[wrap_idx(int'(ptr_q), i)]) begin
            pick_vld = 1'b1;
            pick_idx = wrap_idx(int'(ptr_q), i);
         end
      end
   end

   // State, granted index and round-robin pointer
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         idx_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
      end
   end

   // Next state and channel muxing; grant and outputs derive from state so
   // an asynchronous reset silences the channel in the same cycle
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      ptr_d    = ptr_q;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      ready    = '0;
      grant    = '0;
      unique case (state_q)
         IDLE: begin
            if (io.en_i && pick_vld) begin
               idx_d   = pick_idx;
               ptr_d   = wrap_idx(int'(pick_idx), 1);
               state_d = HDR_EN ? HEADER : DATA;
            end
         end
         HEADER: begin
            grant[idx_q] = 1'b1;
            tx_valid     = 1'b1;
            tx_data      = HDR_BASE + 8'(idx_q);
            if (io.tx_data_ready_i) state_d = DATA;
         end
         DATA: begin
            grant[idx_q] = 1'b1;
            tx_valid     = io.req_valid_i[idx_q];
            tx_data      = io.req_valid_i[idx_q] ? req_byte[idx_q] : 8'h00;
            ready[idx_q] = io.tx_data_ready_i;
            if (io.req_valid_i[idx_q] && io.tx_data_ready_i && io.req_last_i[idx_q]) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign io.req_ready_o     = ready;
   assign io.grant_o         = grant;
   assign io.tx_data_valid_o = tx_valid;
   assign io.tx_data_o       = tx_data;
   assign io.busy_o          = (state_q != IDLE);

endmodule
